// File: rtl/axi_line_master_pkg.sv
// Shared types and constants for the cache-line AXI4 master and its beat counter.
package axi_line_master_pkg;

    localparam int LINE_BEATS = 4;
    localparam int LINE_BITS  = 128;
    localparam int AXI_ID_W   = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_XFER,
        ST_WR_RESP,
        ST_DONE
    } line_state_e;

    function automatic logic resp_bad(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_line_master_beat_counter.sv
// Beat index within one line burst; shared by the R and W channels.
module axi_beat_counter
    import axi_line_master_pkg::*;
#(
    parameter int BEATS = LINE_BEATS,
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    assign last = (count == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/axi_line_master.sv
// Turns one cache-line read refill or writeback into a four-beat AXI4 INCR burst
// and reports completion with a single-cycle done pulse.
module axi_line_master
    import axi_line_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BEATS  = LINE_BEATS,
    parameter int BEAT_W = LINE_BITS / LINE_BEATS,
    localparam int LINE_W = BEAT_W * BEATS,
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid_i,
    input  logic                req_rw_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [LINE_W-1:0]   req_data_i,
    output logic [LINE_W-1:0]   rd_data_o,
    output logic                rd_over_o,
    output logic                wr_over_o,
    output logic                err_o,
    output logic                busy_o,

    output logic [AXI_ID_W-1:0] m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,

    input  logic [BEAT_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,

    output logic [AXI_ID_W-1:0] m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,

    output logic [BEAT_W-1:0]   m_axi_wdata,
    output logic [BEAT_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,

    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);

    line_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic [LINE_W-1:0] rd_data_q;
    logic              rw_q;
    logic              err_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic              accept;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic              r_last;
    logic              w_last;

    logic r_hs, aw_hs, w_hs, b_hs;

    assign m_axi_arid    = '0;
    assign m_axi_awid    = '0;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_wstrb   = '1;

    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wdata   = data_q[int'(w_cnt)*BEAT_W +: BEAT_W];
    assign m_axi_wlast   = w_last;
    assign rd_data_o     = rd_data_q;
    assign busy_o        = (state_q != ST_IDLE);

    assign r_hs  = m_axi_rvalid  & m_axi_rready;
    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;

    axi_beat_counter #(.BEATS(BEATS)) u_r_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .inc   (r_hs),
        .count (r_cnt),
        .last  (r_last)
    );

    axi_beat_counter #(.BEATS(BEATS)) u_w_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .inc   (w_hs),
        .count (w_cnt),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture; the low address bits are dropped so the burst is line aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
        end else if (accept) begin
            addr_q <= req_addr_i & ~(ADDR_W'(15));
            data_q <= req_data_i;
            rw_q   <= req_rw_i;
        end
    end

    // AW and the last W beat may complete in either order, so each is tracked separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (accept) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs && w_last) begin
                w_done_q <= 1'b1;
            end
        end
    end

    // Sticky error: bad responses and rlast misplacement are reported with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept || state_q == ST_DONE) begin
            err_q <= 1'b0;
        end else begin
            if (r_hs && (resp_bad(m_axi_rresp) || (m_axi_rlast != r_last))) begin
                err_q <= 1'b1;
            end
            if (b_hs && resp_bad(m_axi_bresp)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (r_hs) begin
            rd_data_q[int'(r_cnt)*BEAT_W +: BEAT_W] <= m_axi_rdata;
        end
    end

    // Every valid comes from registered state only, so no ready can loop back into a valid.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        rd_over_o     = 1'b0;
        wr_over_o     = 1'b0;
        err_o         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = req_rw_i ? ST_RD_ADDR : ST_WR_XFER;
                end
            end
            ST_RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && r_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_WR_XFER: begin
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                if ((aw_done_q || m_axi_awready) &&
                    (w_done_q || (m_axi_wready && w_last))) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rd_over_o = rw_q;
                wr_over_o = !rw_q;
                err_o     = err_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Randomised scoreboard bench for axi_line_master with a behavioural AXI slave.
`timescale 1ns/1ps
module tb_axi_line_master;
    import axi_line_master_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid_i, req_rw_i;
    logic [31:0]  req_addr_i;
    logic [127:0] req_data_i;
    logic [127:0] rd_data_o;
    logic         rd_over_o, wr_over_o, err_o, busy_o;
    logic [AXI_ID_W-1:0] m_axi_arid, m_axi_awid;
    logic [31:0]  m_axi_araddr, m_axi_awaddr, m_axi_rdata, m_axi_wdata;
    logic [7:0]   m_axi_arlen, m_axi_awlen;
    logic [2:0]   m_axi_arsize, m_axi_awsize;
    logic [1:0]   m_axi_arburst, m_axi_awburst, m_axi_rresp, m_axi_bresp;
    logic         m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic         m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [3:0]   m_axi_wstrb;
    logic         m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    axi_line_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_rw_i(req_rw_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .rd_data_o(rd_data_o), .rd_over_o(rd_over_o),
        .wr_over_o(wr_over_o), .err_o(err_o), .busy_o(busy_o),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct {
        bit           is_read;
        logic [127:0] line;
        bit           err;
        longint       issue;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [127:0] last_rd = '0;

    // Current slave-side job and slave behaviour knobs
    bit           job_live = 0;
    bit           job_read = 0;
    logic [31:0]  job_addr = '0;
    logic [127:0] job_line = '0;
    logic [7:0]   job_resp = '0;
    int           job_rlast_fault = 0;
    int           job_early = 0;
    logic [1:0]   job_bresp = '0;
    int ar_pct = 100, aw_pct = 100, w_pct = 100, r_pct = 100, b_pct = 100;
    int ar_delay = 0, aw_delay = 0;
    bit r_toggle = 0;

    bit ar_seen, aw_seen, b_pend, b_done, r_hold, b_hold, r_phase;
    bit ar_prev_wait, aw_prev_wait;
    logic [31:0] ar_prev_addr, aw_prev_addr;
    int r_idx, w_idx, ar_wait, aw_wait;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearSlaveFlags();
        ar_seen = 0; aw_seen = 0; b_pend = 0; b_done = 0; r_hold = 0; b_hold = 0;
        r_phase = 0; ar_prev_wait = 0; aw_prev_wait = 0; r_idx = 0; w_idx = 0;
        ar_wait = 0; aw_wait = 0;
    endtask

    task automatic setSlave(input int arp, input int awp, input int wp, input int rp,
                            input int bp, input int ard, input int awd, input bit tog);
        ar_pct = arp; aw_pct = awp; w_pct = wp; r_pct = rp; b_pct = bp;
        ar_delay = ard; aw_delay = awd; r_toggle = tog;
    endtask

    // Behavioural AXI slave: drives at the falling edge, evaluates handshakes 1 ns later
    initial begin
        m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
        m_axi_bvalid = 0; m_axi_bresp = '0;
        clearSlaveFlags();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
                m_axi_rvalid = 0; m_axi_bvalid = 0;
                clearSlaveFlags();
                continue;
            end
            m_axi_arready = (ar_wait >= ar_delay) && ($urandom_range(0, 99) < ar_pct);
            m_axi_awready = (aw_wait >= aw_delay) && ($urandom_range(0, 99) < aw_pct);
            m_axi_wready  = ($urandom_range(0, 99) < w_pct);
            if (!r_hold) begin
                if (ar_seen && r_idx < 4) begin
                    r_phase = !r_phase;
                    m_axi_rvalid = r_toggle ? r_phase : ($urandom_range(0, 99) < r_pct);
                    m_axi_rdata  = job_line[r_idx*32 +: 32];
                    m_axi_rresp  = job_resp[r_idx*2 +: 2];
                    m_axi_rlast  = (r_idx == 3 && job_rlast_fault != 2) ||
                                   (job_rlast_fault == 1 && r_idx == job_early);
                end else begin
                    m_axi_rvalid = 0;
                end
            end
            if (!b_hold) begin
                m_axi_bvalid = b_pend && ($urandom_range(0, 99) < b_pct);
                m_axi_bresp  = job_bresp;
            end
            #1;
            if (ar_prev_wait) begin
                checkOutput("ar_valid_held", m_axi_arvalid, 1);
                checkOutput("ar_addr_stable", m_axi_araddr, ar_prev_addr);
            end
            if (m_axi_arvalid) begin
                if (m_axi_arready) begin
                    checkOutput("ar_expected", ar_seen, !(job_live && job_read));
                    checkOutput("araddr", m_axi_araddr, job_addr & 32'hFFFF_FFF0);
                    checkOutput("ar_fields", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst},
                                {4'd0, 8'd3, 3'd2, 2'd1});
                    ar_seen = 1; ar_prev_wait = 0; ar_wait = 0;
                end else begin
                    ar_prev_wait = 1; ar_prev_addr = m_axi_araddr; ar_wait++;
                end
            end else begin
                ar_prev_wait = 0;
            end
            if (aw_prev_wait) begin
                checkOutput("aw_valid_held", m_axi_awvalid, 1);
                checkOutput("aw_addr_stable", m_axi_awaddr, aw_prev_addr);
            end
            if (m_axi_awvalid) begin
                if (m_axi_awready) begin
                    checkOutput("aw_expected", aw_seen, !(job_live && !job_read));
                    checkOutput("awaddr", m_axi_awaddr, job_addr & 32'hFFFF_FFF0);
                    checkOutput("aw_fields", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst},
                                {4'd0, 8'd3, 3'd2, 2'd1});
                    aw_seen = 1; aw_prev_wait = 0; aw_wait = 0;
                end else begin
                    aw_prev_wait = 1; aw_prev_addr = m_axi_awaddr; aw_wait++;
                end
            end else begin
                aw_prev_wait = 0;
            end
            if (m_axi_rvalid) begin
                if (m_axi_rready) begin
                    r_idx++; r_hold = 0;
                end else begin
                    r_hold = 1;
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                checkOutput("w_expected", (job_live && !job_read && w_idx < 4), 1);
                if (w_idx < 4) begin
                    checkOutput("wdata", m_axi_wdata, job_line[w_idx*32 +: 32]);
                    checkOutput("wlast", m_axi_wlast, (w_idx == 3));
                end
                checkOutput("wstrb", m_axi_wstrb, 4'hF);
                w_idx++;
            end
            if (aw_seen && w_idx == 4 && !b_done) b_pend = 1;
            if (m_axi_bvalid) begin
                if (m_axi_bready) begin
                    b_pend = 0; b_hold = 0; b_done = 1;
                end else begin
                    b_hold = 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a done pulse appears
    initial begin
        exp_t e;
        longint lat;
        forever begin
            @(negedge clk);
            #2;
            if (rd_over_o || wr_over_o) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", {rd_over_o, wr_over_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    lat = ($time - 2 - e.issue) / 10;
                    checkOutput("done_kind", {rd_over_o, wr_over_o}, e.is_read ? 2'b10 : 2'b01);
                    checkOutput("err_o", err_o, e.err);
                    checkOutput("busy_at_done", busy_o, 1);
                    if (e.is_read) begin
                        checkOutput("rd_data", rd_data_o, e.line);
                        last_rd = e.line;
                    end else begin
                        checkOutput("rd_data_hold", rd_data_o, last_rd);
                    end
                    if (e.lat != 0) checkOutput("done_latency", lat, e.lat);
                end
            end else if (err_o) begin
                checkOutput("err_without_done", err_o, 0);
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        #3;
        rst_n = 0;
        #1;
        checkOutput("reset_ctrl",
                    {rd_over_o, wr_over_o, err_o, busy_o, m_axi_arvalid, m_axi_rready,
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast,
                     m_axi_araddr, m_axi_awaddr, m_axi_wdata}, 0);
        checkOutput("reset_rd_data", rd_data_o, 0);
        exp_q.delete();
        job_live = 0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic applyStimulus(input bit is_read, input logic [31:0] addr,
                                 input logic [127:0] line, input logic [7:0] resp,
                                 input int rlast_fault, input int early,
                                 input logic [1:0] bresp, input int lat,
                                 input bit spur, input bit wait_done);
        exp_t e;
        int guard;
        guard = 0;
        while (busy_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        job_read = is_read; job_addr = addr; job_line = line; job_resp = resp;
        job_rlast_fault = rlast_fault; job_early = early; job_bresp = bresp;
        clearSlaveFlags();
        job_live = 1;
        e.is_read = is_read;
        e.line    = line;
        e.err     = is_read ? (resp != 0 || rlast_fault != 0) : (bresp != 0);
        e.issue   = $time;
        e.lat     = lat;
        exp_q.push_back(e);
        req_valid_i = 1;
        req_rw_i    = is_read;
        req_addr_i  = addr;
        req_data_i  = is_read ? {$urandom, $urandom, $urandom, $urandom} : line;
        @(negedge clk);
        req_valid_i = 0;
        checkOutput("busy_after_accept", busy_o, 1);
        if (!wait_done) return;
        guard = 0;
        while (busy_o && guard < 500) begin
            req_valid_i = spur && ($urandom_range(0, 2) == 0);
            req_rw_i    = $urandom_range(0, 1);
            req_addr_i  = $urandom;
            req_data_i  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            guard++;
        end
        req_valid_i = 0;
        if (guard >= 500) begin
            checkOutput("done_timeout", 0, 1);
            doReset();
        end
    endtask

    function automatic logic [7:0] randResp();
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) r[b*2 +: 2] = 2'($urandom_range(1, 3));
        return r;
    endfunction

    initial begin
        int g, rf;
        logic [127:0] ln;
        req_valid_i = 0; req_rw_i = 0; req_addr_i = '0; req_data_i = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_ctrl",
                    {rd_over_o, wr_over_o, err_o, busy_o, m_axi_arvalid, m_axi_rready,
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast,
                     m_axi_araddr, m_axi_awaddr, m_axi_wdata}, 0);
        checkOutput("reset_rd_data", rd_data_o, 0);
        @(negedge clk);
        rst_n = 1;

        $display("[TB] minimum-latency read and write");
        setSlave(100, 100, 100, 100, 100, 0, 0, 0);
        applyStimulus(1, 32'h8000_0014, {32'h44, 32'h33, 32'h22, 32'h11}, 8'h00, 0, 0, 2'b00, 6, 0, 1);
        applyStimulus(0, 32'h0000_2008, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b00, 6, 0, 1);

        $display("[TB] write with awready held off for 5 cycles");
        setSlave(100, 100, 100, 100, 100, 0, 5, 0);
        applyStimulus(0, 32'h0000_1000, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA},
                      8'h00, 0, 0, 2'b00, 8, 0, 1);

        $display("[TB] read with toggling rvalid and late arready");
        setSlave(100, 100, 100, 100, 100, 3, 0, 1);
        applyStimulus(1, 32'h1234_567C, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b00, 0, 0, 1);

        $display("[TB] read error response then clean read");
        setSlave(100, 100, 100, 100, 100, 0, 0, 0);
        applyStimulus(1, 32'h0000_4000, {$urandom, $urandom, $urandom, $urandom}, 8'h08, 0, 0, 2'b00, 6, 0, 1);
        applyStimulus(1, 32'h0000_4010, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b00, 6, 0, 1);
        applyStimulus(1, 32'h0000_4020, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 2, 0, 2'b00, 6, 0, 1);
        applyStimulus(0, 32'h0000_4030, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b11, 6, 0, 1);

        $display("[TB] reset during write beat 2");
        applyStimulus(0, 32'h0000_5000, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b00, 0, 0, 0);
        g = 0;
        while (w_idx < 2 && g < 50) begin
            @(negedge clk);
            #2;
            g++;
        end
        if (g >= 50) checkOutput("reset_wait_timeout", 0, 1);
        doReset();
        applyStimulus(1, 32'h0000_6004, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b00, 6, 0, 1);

        $display("[TB] requests pulsed while busy");
        applyStimulus(1, 32'h0000_7000, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b00, 6, 1, 1);
        applyStimulus(0, 32'h0000_7100, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 0, 0, 2'b00, 6, 1, 1);

        $display("[TB] randomised traffic");
        for (int t = 0; t < 40; t++) begin
            setSlave($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                     $urandom_range(30, 100), $urandom_range(30, 100),
                     $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            rf = $urandom_range(0, 9);
            rf = (rf == 0) ? 1 : (rf == 1) ? 2 : 0;
            ln = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus($urandom_range(0, 1), $urandom, ln, randResp(), rf,
                          $urandom_range(0, 2),
                          ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                          0, $urandom_range(0, 1), 1);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- Downstream neighbour of the bus controller.
- Converts one 128-bit cache-line request (read refill or dirty-line writeback) into an AXI4 INCR burst of four 32-bit beats.
- Returns the assembled line with a one-cycle read-done pulse, or a one-cycle write-done pulse after the B response.
- Sole AXI master of the core.
- Top level ties arsize/awsize=3'b010, arburst/awburst=INCR, wstrb=4'hF, arid/awid=0.

Parameters:
- ADDR_W, 32, address width
- BEAT_W, 32, AXI data width per beat
- BEATS, 4, beats per line; LINE_W = BEAT_W*BEATS = 128

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  one-cycle request pulse from bus controller
req_rw_i  in  1  1=read line, 0=write line
req_addr_i  in  ADDR_W  line address; bits [3:0] ignored
req_data_i  in  LINE_W  writeback line; beat k = bits [32k+31:32k]
rd_data_o  out  LINE_W  assembled read line
rd_over_o  out  1  read-done pulse
wr_over_o  out  1  write-done pulse
err_o  out  1  pulse with either done pulse on a bad response or protocol violation
busy_o  out  1  high from accept to done pulse inclusive
m_axi_araddr / m_axi_arlen / m_axi_arvalid  out  ADDR_W / 8 / 1  AR channel
m_axi_arready  in  1  AR channel ready
m_axi_rdata / m_axi_rresp / m_axi_rlast / m_axi_rvalid  in  BEAT_W / 2 / 1 / 1  R channel
m_axi_rready  out  1  R channel ready
m_axi_awaddr / m_axi_awlen / m_axi_awvalid  out  ADDR_W / 8 / 1  AW channel
m_axi_awready  in  1  AW channel ready
m_axi_wdata / m_axi_wlast / m_axi_wvalid  out  BEAT_W / 1 / 1  W channel
m_axi_wready  in  1  W channel ready
m_axi_bresp / m_axi_bvalid  in  2 / 1  B channel
m_axi_bready  out  1  B channel ready

Behaviour:
- Reset (asynchronous): all outputs 0, rd_data_o=0, FSM=IDLE. Assertion mid-burst abandons the transfer with no done pulse.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP, DONE.
- IDLE: on req_valid_i, latch {req_addr_i[ADDR_W-1:4],4'b0}, rw and data.
  - rw=1 goes to RD_ADDR; rw=0 goes to WR_XFER.
  - req_valid_i outside IDLE is ignored.
- arlen/awlen are constant BEATS-1 (8'd3).
- RD_ADDR: arvalid=1 from the cycle after accept, held (address stable) until arready, then RD_DATA.
- RD_DATA: rready=1; beat counter 0..3; beat k is written to rd_data_o[32k+31:32k].
  - After the beat-3 handshake, go to DONE.
  - rlast on beat<3, or missing on beat 3, sets the error flag. Still count 4 beats, then finish.
  - rresp!=0 on any beat sets the error flag.
- WR_XFER: awvalid and wvalid are raised together on entry and drop independently on their own handshakes.
  - wdata = beat k of the latched line; wlast=1 on beat 3.
  - Go to WR_RESP once both AW done and beat 3 accepted, in either order.
- WR_RESP: bready=1; bvalid goes to DONE; bresp!=0 sets the error flag.
- DONE: one cycle.
  - rd_over_o or wr_over_o =1; err_o = error flag.
  - Clear the flag, return to IDLE.
  - rd_data_o holds until the next read's first beat.
- Minimum latency with an always-ready slave:
  - req pulse at cycle 0; arvalid/awvalid at cycle 1.
  - Read: beats at cycles 2-5 (rvalid from cycle 2), rd_over_o at cycle 6.
  - Write: beats at cycles 1-4, bvalid at cycle 5, wr_over_o at cycle 6.
- Every valid is held until its ready (AXI rule); no combinational ready-to-valid path.

Decomposition:
- Shared package holds: state encoding, AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY, BEATS/LINE_W constants.
- One sub-module, axi_beat_counter: 2-bit counter with clear, increment-on-handshake and last flag. Used for both R and W.

Test Plan:
- Read at 0x8000_0014, always-ready slave returning 0x11,0x22,0x33,0x44 -> araddr=0x8000_0010, arlen=3; rd_over_o at cycle 6; rd_data_o=0x00000044_00000033_00000022_00000011; err_o=0.
- Write 0xDDDD..CCCC..BBBB..AAAA to 0x0000_1000, awready delayed 5 cycles while wready=1 -> W beats 0xAAAAAAAA first, wlast on beat 3; wr_over_o one cycle after bvalid.
- Read with rvalid toggling every other cycle and arready after 3 cycles -> arvalid/araddr stable while waiting; 4 beats captured in order; single rd_over_o pulse.
- Read with rresp=2'b10 on beat 1 -> all 4 beats consumed; rd_over_o and err_o pulse together; next read with OKAY gives err_o=0.
- rst_n low during beat 2 of a write -> all AXI valids drop immediately, no wr_over_o; a new read afterwards completes normally.
- req_valid_i pulsed again while busy_o=1 -> ignored; exactly one done pulse and one AR/AW issued.
